pattern_sequencer: RTL and testbench
====================================

Name: pattern_sequencer

Overview:
- Frame-synchronous controller that drives the caleidoscope generator's SWITCH pattern-select input.
- Advances the pattern on a debounced button press, or on an auto-advance frame timer.
- Pattern changes take effect only at a vsync rising edge, so a frame never shows a mid-frame change.
- Sits in the pixel clock domain between the board button and the generator.

Parameters:
- C_switch_bits, 3, width of the switch output.
- C_num_patterns, 8, number of patterns; sequence wraps at C_num_patterns-1. Must be ≤ 2**C_switch_bits.
- C_reset_pattern, 4, switch value after reset. Must be < C_num_patterns.
- C_debounce_bits, 16, debounce counter width; stable time is 2**C_debounce_bits cycles (≈2.6 ms at 25 MHz).
- C_auto_frames, 600, frames between auto-advances (10 s at 60 Hz). Must be ≥ 1.
- C_frame_bits, 10, frame counter width. Must satisfy 2**C_frame_bits ≥ C_auto_frames.

Ports:
- clk_pixel, in, 1: pixel clock. All logic runs on its rising edge.
- reset, in, 1: asynchronous, active-high.
- btn, in, 1: raw button, asynchronous to clk_pixel, active-high.
- auto_en, in, 1: enables auto-advance. Synchronous to clk_pixel.
- vsync, in, 1: generator vsync, clk_pixel synchronous. A frame boundary is a 0→1 transition.
- switch, out, C_switch_bits: pattern select to the generator.
- switch_changed, out, 1: one-cycle pulse in the cycle after switch updates.
- pending, out, 1: an advance is queued and waits for the next frame boundary.
- btn_stable, out, 1: debounced button level, for LED.

Behaviour:
- Reset (asynchronous assert; deassert acts at the next edge) sets:
  - switch=C_reset_pattern;
  - switch_changed=0, pending=0, btn_stable=0;
  - sync flops=0, debounce counter=0, frame counter=0;
  - vsync_prev=1, so a vsync already high at reset release is not a frame boundary.
- Button synchroniser: 2 flops, btn → s0 → s1.
- Debounce:
  - If s1==btn_stable, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter is all-ones and s1≠btn_stable: btn_stable<=s1 and the counter clears.
  - Result: the input must differ continuously for 2**C_debounce_bits cycles before it is accepted.
  - Any glitch shorter than that leaves btn_stable unchanged.
- press_evt is a combinational rising edge of btn_stable (btn_stable=1 and its previous registered value=0). Releases generate nothing.
- frame_evt = vsync & ~vsync_prev. vsync_prev updates every cycle.
- Auto timer:
  - With auto_en=0, the frame counter is held at 0.
  - With auto_en=1, it increments on each frame_evt.
  - auto_evt is asserted when frame_evt fires with counter==C_auto_frames-1; the counter then returns to 0.
  - A press_evt clears the counter, restarting the auto interval.
- Control FSM, two states: IDLE (pending=0) and ARMED (pending=1).
  - IDLE→ARMED on press_evt or auto_evt, without a simultaneous frame_evt.
  - ARMED→IDLE on frame_evt, with an advance.
  - IDLE with press_evt and frame_evt in the same cycle: advance immediately and stay IDLE. auto_evt always coincides with frame_evt, so it advances in the same cycle.
  - Further events while ARMED collapse into one advance. At most one advance per frame.
  - Events in the same cycle as an ARMED→IDLE advance are absorbed; they do not re-arm.
- Advance: switch <= (switch==C_num_patterns-1) ? 0 : switch+1, registered. switch_changed=1 in the following cycle only.
- Latency:
  - btn edge to btn_stable: 2 sync cycles + 2**C_debounce_bits cycles + 1.
  - Frame boundary to switch update: 1 cycle after the vsync rise is sampled.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Package video_ctrl_pkg holds C_switch_bits, the default pattern constant (3'b100), and the default debounce width.
- Sub-module btn_debounce (sync + debounce, outputs btn_stable and press_evt), reusable for other board buttons.
- FSM, frame counter and switch register stay in pattern_sequencer.

Test Plan (C_debounce_bits=3, C_auto_frames=3, C_num_patterns=8, C_reset_pattern=4):
1. Reset, then hold btn=0 and toggle vsync → switch=4, pending=0, switch_changed never asserted.
2. btn high for 4 cycles, then low → btn_stable stays 0, no advance. btn high for 12 cycles → btn_stable=1 and pending=1; next vsync rise → switch=5 one cycle later, switch_changed pulses once, pending=0.
3. Three clean presses within one frame → exactly one advance at the next vsync rise (5→6).
4. auto_en=1, btn idle → advances on the 3rd, 6th and 9th vsync rises. Starting at switch=6: 6→7→0→1, which checks the wrap.
5. Press debounces in the same cycle as a vsync rise → immediate advance, pending stays 0, frame counter cleared (next auto advance 3 frames later).
6. Assert reset with pending=1 and switch=2 → switch=4 and pending=0 at once (asynchronous). Release reset with vsync already high → no advance until vsync goes low, then rises again.

Source files
------------

// File: rtl/video_ctrl_pkg.sv
// ============================================================================
// video_ctrl_pkg : shared constants and types for the video control blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package video_ctrl_pkg;

    localparam int C_SWITCH_BITS = 3;
    localparam logic [C_SWITCH_BITS-1:0] C_DEFAULT_PATTERN = 3'b100;
    localparam int C_DEBOUNCE_BITS = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/btn_debounce.sv
// ============================================================================
// btn_debounce : two-flop synchroniser plus counter debounce for one button
// Rev 1.0
// ============================================================================
`default_nettype none

module btn_debounce
    import video_ctrl_pkg::*;
#(
    parameter int C_debounce_bits = C_DEBOUNCE_BITS
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic btn_stable_o,
    output logic press_evt_o
);

    logic                       s0_q;
    logic                       s1_q;
    logic                       stable_q;
    logic                       stable_d;
    logic                       stable_prev_q;
    logic [C_debounce_bits-1:0] cnt_q;
    logic [C_debounce_bits-1:0] cnt_d;

    // The synchronised level must disagree for a full counter wrap before it is taken.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        if (s1_q == stable_q) begin
            cnt_d = '0;
        end else if (&cnt_q) begin
            stable_d = s1_q;
            cnt_d    = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s0_q          <= 1'b0;
            s1_q          <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            cnt_q         <= '0;
        end else begin
            s0_q          <= btn_i;
            s1_q          <= s0_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            cnt_q         <= cnt_d;
        end
    end

    assign btn_stable_o = stable_q;
    assign press_evt_o  = stable_q & ~stable_prev_q;

endmodule

`default_nettype wire

// File: rtl/pattern_sequencer.sv
// ============================================================================
// pattern_sequencer : frame-synchronous pattern select with button/auto advance
// Rev 1.0
// ============================================================================
`default_nettype none

module pattern_sequencer
    import video_ctrl_pkg::*;
#(
    parameter int C_switch_bits   = C_SWITCH_BITS,
    parameter int C_num_patterns  = 8,
    parameter int C_reset_pattern = int'(C_DEFAULT_PATTERN),
    parameter int C_debounce_bits = C_DEBOUNCE_BITS,
    parameter int C_auto_frames   = 600,
    parameter int C_frame_bits    = 10
) (
    input  logic                     clk_pixel,
    input  logic                     reset,
    input  logic                     btn,
    input  logic                     auto_en,
    input  logic                     vsync,
    output logic [C_switch_bits-1:0] switch,
    output logic                     switch_changed,
    output logic                     pending,
    output logic                     btn_stable
);

    localparam logic [C_switch_bits-1:0] C_SW_LAST    = C_switch_bits'(C_num_patterns - 1);
    localparam logic [C_switch_bits-1:0] C_SW_RESET   = C_switch_bits'(C_reset_pattern);
    localparam logic [C_frame_bits-1:0]  C_FRAME_LAST = C_frame_bits'(C_auto_frames - 1);

    logic                     press_evt;
    logic                     frame_evt;
    logic                     auto_evt;
    logic                     vsync_prev_q;
    logic [C_frame_bits-1:0]  frame_cnt_q;
    logic [C_frame_bits-1:0]  frame_cnt_d;
    logic [C_switch_bits-1:0] switch_q;
    logic [C_switch_bits-1:0] switch_d;
    logic                     changed_q;
    logic                     pending_q;
    seq_state_t               state_q;

    btn_debounce #(
        .C_debounce_bits (C_debounce_bits)
    ) u_btn_debounce (
        .clk_i        (clk_pixel),
        .rst_i        (reset),
        .btn_i        (btn),
        .btn_stable_o (btn_stable),
        .press_evt_o  (press_evt)
    );

    assign frame_evt = vsync & ~vsync_prev_q;
    assign auto_evt  = auto_en & frame_evt & (frame_cnt_q == C_FRAME_LAST);
    assign switch_d  = (switch_q == C_SW_LAST) ? '0 : switch_q + 1'b1;

    // A manual press restarts the auto interval so the two never fire back to back.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (!auto_en || press_evt) begin
            frame_cnt_d = '0;
        end else if (auto_evt) begin
            frame_cnt_d = '0;
        end else if (frame_evt) begin
            frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= 1'b0;
            switch_q     <= C_SW_RESET;
            changed_q    <= 1'b0;
            vsync_prev_q <= 1'b1;
            frame_cnt_q  <= '0;
        end else begin
            vsync_prev_q <= vsync;
            frame_cnt_q  <= frame_cnt_d;
            changed_q    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (press_evt || auto_evt) begin
                        if (frame_evt) begin
                            switch_q  <= switch_d;
                            changed_q <= 1'b1;
                        end else begin
                            state_q   <= ST_ARMED;
                            pending_q <= 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    // Anything arriving with this boundary is folded into this advance.
                    if (frame_evt) begin
                        switch_q  <= switch_d;
                        changed_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        pending_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign switch         = switch_q;
    assign switch_changed = changed_q;
    assign pending        = pending_q;

endmodule

`default_nettype wire

// File: tb/tb_pattern_sequencer.sv
// ============================================================================
// tb_pattern_sequencer : directed and randomized bench with a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pattern_sequencer;

    localparam int SB = 3;
    localparam int NP = 8;
    localparam int RP = 4;
    localparam int DB = 3;
    localparam int AF = 3;
    localparam int FB = 2;

    logic          clk_pixel = 1'b0;
    logic          reset;
    logic          btn;
    logic          auto_en;
    logic          vsync;
    logic [SB-1:0] switch;
    logic          switch_changed;
    logic          pending;
    logic          btn_stable;

    int n_checks = 0;
    int n_errors = 0;
    int chg_seen = 0;

    int m_s0, m_s1, m_stab, m_stab_prev, m_run;
    int m_vprev, m_frames, m_pend, m_sw, m_chg;

    pattern_sequencer #(
        .C_switch_bits   (SB),
        .C_num_patterns  (NP),
        .C_reset_pattern (RP),
        .C_debounce_bits (DB),
        .C_auto_frames   (AF),
        .C_frame_bits    (FB)
    ) dut (
        .clk_pixel      (clk_pixel),
        .reset          (reset),
        .btn            (btn),
        .auto_en        (auto_en),
        .vsync          (vsync),
        .switch         (switch),
        .switch_changed (switch_changed),
        .pending        (pending),
        .btn_stable     (btn_stable)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic check_value(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_s0 = 0; m_s1 = 0; m_stab = 0; m_stab_prev = 0; m_run = 0;
        m_vprev = 1; m_frames = 0; m_pend = 0; m_sw = RP; m_chg = 0;
    endtask

    // One clock edge of the sequencer described by its rules, not its registers.
    task automatic model_edge();
        bit press, frame, auto_e, adv;
        int old_stab;
        if (reset) begin
            model_reset();
            return;
        end
        press  = (m_stab == 1) && (m_stab_prev == 0);
        frame  = (vsync == 1'b1) && (m_vprev == 0);
        auto_e = auto_en && frame && (m_frames == AF - 1);
        if (!auto_en || press || auto_e) m_frames = 0;
        else if (frame) m_frames = m_frames + 1;
        adv = 0;
        if (m_pend == 1) begin
            if (frame) begin adv = 1; m_pend = 0; end
        end else if (press || auto_e) begin
            if (frame) adv = 1;
            else m_pend = 1;
        end
        m_chg = adv ? 1 : 0;
        if (adv) m_sw = (m_sw + 1) % NP;
        old_stab = m_stab;
        if (m_s1 != m_stab) begin
            m_run = m_run + 1;
            if (m_run == (1 << DB)) begin
                m_stab = m_s1;
                m_run  = 0;
            end
        end else begin
            m_run = 0;
        end
        m_stab_prev = old_stab;
        m_s1 = m_s0;
        m_s0 = btn;
        m_vprev = vsync;
    endtask

    task automatic step();
        @(posedge clk_pixel);
        model_edge();
        #1;
        if (switch_changed === 1'b1) chg_seen++;
        check_value("switch", switch, m_sw);
        check_value("switch_changed", switch_changed, m_chg);
        check_value("pending", pending, m_pend);
        check_value("btn_stable", btn_stable, m_stab);
    endtask

    task automatic frame_pulse();
        vsync = 1'b0;
        repeat (2) step();
        vsync = 1'b1;
        repeat (2) step();
        vsync = 1'b0;
    endtask

    task automatic press_full();
        btn = 1'b1;
        repeat (12) step();
        btn = 1'b0;
        repeat (12) step();
    endtask

    initial begin
        int chg_base;
        int found;
        reset = 1'b1; btn = 1'b0; auto_en = 1'b0; vsync = 1'b0;
        model_reset();
        #1;
        check_value("rst_switch", switch, RP);
        check_value("rst_pending", pending, 0);
        check_value("rst_changed", switch_changed, 0);
        check_value("rst_btn_stable", btn_stable, 0);
        repeat (2) step();
        reset = 1'b0;

        // Idle frames with no button: nothing moves.
        chg_base = chg_seen;
        repeat (4) frame_pulse();
        check_value("t1_switch", switch, 4);
        check_value("t1_changes", chg_seen - chg_base, 0);

        // Short glitch rejected, long press arms then advances at the boundary.
        btn = 1'b1;
        repeat (4) step();
        btn = 1'b0;
        repeat (12) step();
        check_value("t2_glitch_stable", btn_stable, 0);
        check_value("t2_glitch_pending", pending, 0);
        btn = 1'b1;
        repeat (12) step();
        check_value("t2_stable", btn_stable, 1);
        check_value("t2_pending", pending, 1);
        btn = 1'b0;
        repeat (12) step();
        chg_base = chg_seen;
        frame_pulse();
        check_value("t2_switch", switch, 5);
        check_value("t2_pending_clr", pending, 0);
        check_value("t2_changes", chg_seen - chg_base, 1);

        // Several presses inside one frame collapse into one advance.
        repeat (3) press_full();
        chg_base = chg_seen;
        frame_pulse();
        check_value("t3_switch", switch, 6);
        check_value("t3_changes", chg_seen - chg_base, 1);

        // Auto-advance every third frame, crossing the wrap.
        auto_en = 1'b1;
        repeat (3) frame_pulse();
        check_value("t4_switch_a", switch, 7);
        repeat (3) frame_pulse();
        check_value("t4_switch_b", switch, 0);
        repeat (3) frame_pulse();
        check_value("t4_switch_c", switch, 1);

        // Press landing on a boundary advances at once and restarts the auto interval.
        vsync = 1'b0;
        btn = 1'b1;
        found = 0;
        for (int k = 0; k < 40 && found == 0; k++) begin
            step();
            if (m_stab == 1 && m_stab_prev == 0) begin
                vsync = 1'b1;
                found = 1;
            end
        end
        check_value("t5_aligned", found, 1);
        step();
        check_value("t5_switch", switch, 2);
        check_value("t5_pending", pending, 0);
        check_value("t5_changed", switch_changed, 1);
        btn = 1'b0;
        repeat (12) step();
        repeat (2) frame_pulse();
        check_value("t5_no_early_auto", switch, 2);
        frame_pulse();
        check_value("t5_auto", switch, 3);

        // Reach switch=2 with an advance queued, then reset asynchronously.
        auto_en = 1'b0;
        for (int k = 0; k < 10 && m_sw != 2; k++) begin
            press_full();
            frame_pulse();
        end
        check_value("t6_pre_switch", switch, 2);
        btn = 1'b1;
        repeat (12) step();
        check_value("t6_pre_pending", pending, 1);
        reset = 1'b1;
        #2;
        check_value("t6_async_switch", switch, 4);
        check_value("t6_async_pending", pending, 0);
        check_value("t6_async_stable", btn_stable, 0);
        model_reset();
        btn = 1'b0;
        vsync = 1'b1;
        auto_en = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        repeat (3) step();
        check_value("t6_hold_high", switch, 4);
        repeat (2) frame_pulse();
        check_value("t6_two_frames", switch, 4);
        frame_pulse();
        check_value("t6_third_frame", switch, 5);

        // Randomized traffic against the model.
        for (int i = 0; i < 150; i++) begin
            int len;
            btn = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) auto_en = ~auto_en;
            len = $urandom_range(1, 14);
            repeat (len) begin
                if ($urandom_range(0, 3) == 0) vsync = ~vsync;
                step();
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
